// File: rtl/cpu_wb_arbiter_if.sv
// Writeback bus between the two producers (ALU, load return) and the register-file
// write port owner. The slave modport is the arbiter's view of the bus.
interface cpu_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_waddr;
    logic [DATA_W-1:0] ld_wdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_sel;

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output ld_valid, ld_waddr, ld_wdata,
        input  alu_ready, ld_ready,
        input  rf_we, rf_waddr, rf_wdata, wb_sel
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  ld_valid, ld_waddr, ld_wdata,
        output alu_ready, ld_ready,
        output rf_we, rf_waddr, rf_wdata, wb_sel
    );
endinterface

// File: rtl/cpu_wb_arbiter.sv
// Shares the single register-file write port between the ALU and load writeback paths.
// A same-cycle collision writes the load first and parks the ALU result for one cycle.
module cpu_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    cpu_wb_arbiter_if.slave  wb,
    input  logic             i_stall_cnt_clr,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);
    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t            r_state,      w_state_next;
    logic [ADDR_W-1:0] r_buf_addr,   w_buf_addr_next;
    logic [DATA_W-1:0] r_buf_data,   w_buf_data_next;
    logic              r_rf_we,      w_rf_we_next;
    logic [ADDR_W-1:0] r_rf_waddr,   w_rf_waddr_next;
    logic [DATA_W-1:0] r_rf_wdata,   w_rf_wdata_next;
    logic              r_wb_sel,     w_wb_sel_next;
    logic [CNT_W-1:0]  r_stall_cnt,  w_stall_cnt_next;
    logic              w_collide;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_wb_sel    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_buf_addr  <= w_buf_addr_next;
            r_buf_data  <= w_buf_data_next;
            r_rf_we     <= w_rf_we_next;
            r_rf_waddr  <= w_rf_waddr_next;
            r_rf_wdata  <= w_rf_wdata_next;
            r_wb_sel    <= w_wb_sel_next;
            r_stall_cnt <= w_stall_cnt_next;
        end
    end

    // In ST_IDLE both producers are ready, so a valid is an accepted request.
    always_comb begin
        w_state_next    = r_state;
        w_buf_addr_next = r_buf_addr;
        w_buf_data_next = r_buf_data;
        w_rf_we_next    = 1'b0;
        w_rf_waddr_next = r_rf_waddr;
        w_rf_wdata_next = r_rf_wdata;
        w_wb_sel_next   = r_wb_sel;
        w_collide       = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                w_rf_we_next    = |r_buf_addr;
                w_rf_waddr_next = r_buf_addr;
                w_rf_wdata_next = r_buf_data;
                w_wb_sel_next   = 1'b0;
                w_state_next    = ST_IDLE;
            end
            default: begin
                if (wb.ld_valid) begin
                    w_rf_we_next    = |wb.ld_waddr;
                    w_rf_waddr_next = wb.ld_waddr;
                    w_rf_wdata_next = wb.ld_wdata;
                    w_wb_sel_next   = 1'b1;
                    if (wb.alu_valid) begin
                        // ALU is the younger instruction: it commits after the load.
                        w_buf_addr_next = wb.alu_waddr;
                        w_buf_data_next = wb.alu_wdata;
                        w_state_next    = ST_DRAIN;
                        w_collide       = 1'b1;
                    end
                end else if (wb.alu_valid) begin
                    w_rf_we_next    = |wb.alu_waddr;
                    w_rf_waddr_next = wb.alu_waddr;
                    w_rf_wdata_next = wb.alu_wdata;
                    w_wb_sel_next   = 1'b0;
                end
            end
        endcase
    end

    // A clear coinciding with a collision still records that collision.
    always_comb begin
        w_stall_cnt_next = r_stall_cnt;
        if (i_stall_cnt_clr) begin
            w_stall_cnt_next = w_collide ? CNT_W'(1) : '0;
        end else if (w_collide && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
        end
    end

    assign wb.alu_ready = (r_state == ST_IDLE);
    assign wb.ld_ready  = (r_state == ST_IDLE);
    assign wb.rf_we     = r_rf_we;
    assign wb.rf_waddr  = r_rf_waddr;
    assign wb.rf_wdata  = r_rf_wdata;
    assign wb.wb_sel    = r_wb_sel;
    assign o_busy       = (r_state == ST_DRAIN);
    assign o_stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Bench for cpu_wb_arbiter: directed and random writeback traffic checked against an
// ordered queue of accepted writes that retires one entry per cycle.
module tb_cpu_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_clr;
    logic        busy,  busy2;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        sel;
    } wr_t;

    wr_t         q[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_sel;
    int          m_cnt16, m_cnt2;

    always #5 clk = ~clk;

    cpu_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) wb  ();
    cpu_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) wb2 ();

    // Second instance sees the same traffic but has a 2-bit collision counter.
    assign wb2.alu_valid = wb.alu_valid;
    assign wb2.alu_waddr = wb.alu_waddr;
    assign wb2.alu_wdata = wb.alu_wdata;
    assign wb2.ld_valid  = wb.ld_valid;
    assign wb2.ld_waddr  = wb.ld_waddr;
    assign wb2.ld_wdata  = wb.ld_wdata;

    cpu_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .wb(wb.slave),
        .i_stall_cnt_clr(stall_clr), .o_busy(busy), .o_stall_cnt(cnt16)
    );

    cpu_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .wb(wb2.slave),
        .i_stall_cnt_clr(stall_clr), .o_busy(busy2), .o_stall_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        $display("[%0t] %s: we=%b addr=%0d data=%h sel=%b busy=%b cnt=%0d/%0d",
                 $time, tag, wb.rf_we, wb.rf_waddr, wb.rf_wdata, wb.wb_sel, busy, cnt16, cnt2);
        chk({tag, ".rf_we"},    32'(wb.rf_we),    32'(m_we));
        chk({tag, ".rf_waddr"}, 32'(wb.rf_waddr), 32'(m_addr));
        chk({tag, ".rf_wdata"}, wb.rf_wdata,      m_data);
        chk({tag, ".wb_sel"},   32'(wb.wb_sel),   32'(m_sel));
        chk({tag, ".busy"},     32'(busy),        32'(q.size() != 0));
        chk({tag, ".stall16"},  32'(cnt16),       32'(m_cnt16));
        chk({tag, ".stall2"},   32'(cnt2),        32'(m_cnt2));
        chk({tag, ".rf_we2"},   32'(wb2.rf_we),   32'(m_we));
    endtask

    task automatic do_reset(input logic av, input logic lv);
        wb.alu_valid = av; wb.alu_waddr = 5'd9; wb.alu_wdata = 32'hA5A5A5A5;
        wb.ld_valid  = lv; wb.ld_waddr  = 5'd9; wb.ld_wdata  = 32'h5A5A5A5A;
        stall_clr = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_sel = 1'b0;
        m_cnt16 = 0; m_cnt2 = 0;
        chk_outputs("reset");
        rst = 1'b0;
    endtask

    // One clock: drive a request pair, advance the reference, then compare.
    task automatic cycle(input string tag,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic clr);
        bit  rdy, coll;
        wr_t w;
        wb.alu_valid = av; wb.alu_waddr = aa; wb.alu_wdata = ad;
        wb.ld_valid  = lv; wb.ld_waddr  = la; wb.ld_wdata  = ld;
        stall_clr = clr;
        rdy  = (q.size() == 0);
        coll = 1'b0;
        chk({tag, ".alu_ready"}, 32'(wb.alu_ready), 32'(rdy));
        chk({tag, ".ld_ready"},  32'(wb.ld_ready),  32'(rdy));
        if (rdy) begin
            if (lv) begin w.addr = la; w.data = ld; w.sel = 1'b1; q.push_back(w); end
            if (av) begin w.addr = aa; w.data = ad; w.sel = 1'b0; q.push_back(w); end
            coll = lv && av;
        end
        if (q.size() != 0) begin
            w = q.pop_front();
            m_we = (w.addr != 0); m_addr = w.addr; m_data = w.data; m_sel = w.sel;
        end else begin
            m_we = 1'b0;
        end
        if (clr) begin
            m_cnt16 = coll ? 1 : 0;
            m_cnt2  = coll ? 1 : 0;
        end else if (coll) begin
            m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
            m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end
        @(posedge clk); #1;
        chk_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; stall_clr = 1'b0;
        wb.alu_valid = 1'b0; wb.alu_waddr = '0; wb.alu_wdata = '0;
        wb.ld_valid  = 1'b0; wb.ld_waddr  = '0; wb.ld_wdata  = '0;

        do_reset(1'b1, 1'b1);
        do_reset(1'b1, 1'b1);
        cycle("t1_idle", 0, 0, 0, 0, 0, 0, 0);

        cycle("t2_alu", 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle("t2_idle", 0, 0, 0, 0, 0, 0, 0);

        cycle("t3_coll",  1, 5'd5, 32'h22, 1, 5'd5, 32'h11, 0);
        cycle("t3_drain", 0, 0, 0, 0, 0, 0, 0);
        cycle("t3_idle",  0, 0, 0, 0, 0, 0, 0);

        cycle("t4_alu0",   1, 5'd0, 32'hFF, 0, 0, 0, 0);
        cycle("t4_coll0",  1, 5'd7, 32'h77, 1, 5'd0, 32'h99, 0);
        cycle("t4_drain",  0, 0, 0, 0, 0, 0, 0);
        cycle("t4_hold",   0, 0, 0, 0, 0, 0, 0);

        cycle("t5_clr", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            cycle("t5_b2b", 1, 5'(i + 10), 32'(32'h1000 + i), 1, 5'(i + 20), 32'(32'h2000 + i), 0);
        cycle("t5_tail", 0, 0, 0, 0, 0, 0, 0);
        chk("t5_stall_is_5", 32'(cnt16), 32'd5);
        chk("t5_stall2_sat", 32'(cnt2),  32'd3);

        cycle("t_clr_inc", 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1);
        cycle("t_clr_inc_drain", 0, 0, 0, 0, 0, 0, 0);

        cycle("t6_coll", 1, 5'd12, 32'hBAD0BAD0, 1, 5'd13, 32'h600D600D, 0);
        do_reset(1'b0, 1'b0);
        cycle("t6_after", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
